// File: rtl/gnrc_fractional_counter_mc_if.sv
// Configuration port of the multi-channel fractional counter: one request per
// accepted valid/ready beat, error pulse reported one cycle later.
interface gnrc_fractional_counter_mc_if #(
   parameter int N  = 8,
   parameter int CH = 4,
   parameter int PW = 8,
   parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic [N-1:0]  cfg_max;
   logic [N-1:0]  cfg_inc;
   logic [N-1:0]  cfg_phase;
   logic [PW-1:0] cfg_npulse;
   logic          cfg_mode;
   logic          cfg_down;
   logic          cfg_sync;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_max, cfg_inc, cfg_phase, cfg_npulse,
             cfg_mode, cfg_down, cfg_sync,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_max, cfg_inc, cfg_phase, cfg_npulse,
             cfg_mode, cfg_down, cfg_sync,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/gnrc_fractional_counter_mc.sv
// CH fractional accumulators (inc per enabled cycle, wrap at max+1, registered tick one cycle later).
// Config ready drops only while the addressed channel holds a pending synchronous config in its shadow.
module gnrc_fractional_counter_mc #(
   parameter int N  = 8,
   parameter int CH = 4,
   parameter int PW = 8,
   parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   gnrc_fractional_counter_mc_if.slave cfg,
   input  logic [CH-1:0]               en_i,
   input  logic [CH-1:0]               clr_i,
   output logic [CH*N-1:0]             cnt_o,
   output logic [CH-1:0]               tick_o,
   output logic [CH-1:0]               done_o,
   output logic [CH-1:0]               pend_o
);

   logic [N-1:0]  cnt_q      [CH];
   logic [N-1:0]  max_q      [CH];
   logic [N-1:0]  inc_q      [CH];
   logic [N-1:0]  phase_q    [CH];
   logic [PW-1:0] npulse_q   [CH];
   logic [PW-1:0] budget_q   [CH];
   logic [N-1:0]  sh_max_q   [CH];
   logic [N-1:0]  sh_inc_q   [CH];
   logic [N-1:0]  sh_phase_q [CH];
   logic [PW-1:0] sh_npulse_q[CH];
   logic [CH-1:0] sh_mode_q, sh_down_q;
   logic [CH-1:0] mode_q, down_q, tick_q, done_q, pend_q;
   logic          err_q;

   logic [CH-1:0] ch_sel;
   logic          ch_ok, cfg_rdy, accept, bad;
   logic [PW-1:0] cfg_np;

   always_comb begin
      ch_sel  = '0;
      cfg_rdy = 1'b1;
      for (int k = 0; k < CH; k++) begin
         if (cfg.cfg_ch == CW'(k)) begin
            ch_sel[k] = 1'b1;
            cfg_rdy   = ~pend_q[k];
         end
      end
      ch_ok  = |ch_sel;
      accept = cfg.cfg_valid & cfg_rdy;
      bad    = (cfg.cfg_inc > cfg.cfg_max) | (cfg.cfg_phase > cfg.cfg_max) | ~ch_ok;
      cfg_np = (cfg.cfg_npulse == '0) ? PW'(1) : cfg.cfg_npulse;
   end

   assign cfg.cfg_ready = cfg_rdy;
   assign cfg.cfg_err   = err_q;

   // N+1-bit intermediates so max = inc = 2^N-1 cannot overflow
   logic [N:0]    modp1  [CH];
   logic [N:0]    up_sum [CH];
   logic [N:0]    dn_dif [CH];
   logic [N-1:0]  nxt_cnt[CH];
   logic [CH-1:0] wrap, hit, load_cfg, to_shadow, run, load_sh;

   always_comb begin
      for (int k = 0; k < CH; k++) begin
         modp1[k]  = {1'b0, max_q[k]} + {{N{1'b0}}, 1'b1};
         up_sum[k] = {1'b0, cnt_q[k]} + {1'b0, inc_q[k]};
         dn_dif[k] = {1'b0, cnt_q[k]} - {1'b0, inc_q[k]};
         if (down_q[k]) begin
            wrap[k]    = inc_q[k] > cnt_q[k];
            nxt_cnt[k] = wrap[k] ? N'(dn_dif[k] + modp1[k]) : N'(dn_dif[k]);
         end else begin
            wrap[k]    = up_sum[k] > {1'b0, max_q[k]};
            nxt_cnt[k] = wrap[k] ? N'(up_sum[k] - modp1[k]) : N'(up_sum[k]);
         end
         hit[k]       = accept & ~bad & ch_sel[k];
         // a clear in the same cycle forces the config to take effect now
         load_cfg[k]  = hit[k] & (~cfg.cfg_sync | ~en_i[k] | done_q[k] | clr_i[k]);
         to_shadow[k] = hit[k] & cfg.cfg_sync & en_i[k] & ~done_q[k] & ~clr_i[k];
         run[k]       = en_i[k] & ~done_q[k] & ~clr_i[k] & ~load_cfg[k];
         load_sh[k]   = pend_q[k] & (clr_i[k] | (run[k] & wrap[k]));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < CH; k++) begin
            cnt_q[k]       <= '0;
            max_q[k]       <= '0;
            inc_q[k]       <= '0;
            phase_q[k]     <= '0;
            npulse_q[k]    <= '0;
            budget_q[k]    <= '0;
            sh_max_q[k]    <= '0;
            sh_inc_q[k]    <= '0;
            sh_phase_q[k]  <= '0;
            sh_npulse_q[k] <= '0;
         end
         sh_mode_q <= '0;
         sh_down_q <= '0;
         mode_q    <= '1;
         down_q    <= '0;
         tick_q    <= '0;
         done_q    <= '0;
         pend_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= accept & bad;
         for (int k = 0; k < CH; k++) begin
            if (load_cfg[k]) begin
               max_q[k]    <= cfg.cfg_max;
               inc_q[k]    <= cfg.cfg_inc;
               phase_q[k]  <= cfg.cfg_phase;
               npulse_q[k] <= cfg_np;
               mode_q[k]   <= cfg.cfg_mode;
               down_q[k]   <= cfg.cfg_down;
               cnt_q[k]    <= cfg.cfg_phase;
               budget_q[k] <= cfg_np;
               tick_q[k]   <= 1'b0;
               done_q[k]   <= 1'b0;
            end else if (load_sh[k]) begin
               max_q[k]    <= sh_max_q[k];
               inc_q[k]    <= sh_inc_q[k];
               phase_q[k]  <= sh_phase_q[k];
               npulse_q[k] <= sh_npulse_q[k];
               mode_q[k]   <= sh_mode_q[k];
               down_q[k]   <= sh_down_q[k];
               cnt_q[k]    <= sh_phase_q[k];
               budget_q[k] <= sh_npulse_q[k];
               tick_q[k]   <= run[k] & wrap[k];
               done_q[k]   <= 1'b0;
               pend_q[k]   <= 1'b0;
            end else if (clr_i[k]) begin
               cnt_q[k]    <= phase_q[k];
               budget_q[k] <= npulse_q[k];
               tick_q[k]   <= 1'b0;
               done_q[k]   <= 1'b0;
            end else if (run[k]) begin
               cnt_q[k]  <= nxt_cnt[k];
               tick_q[k] <= wrap[k];
               if (wrap[k] && !mode_q[k]) begin
                  budget_q[k] <= budget_q[k] - PW'(1);
                  done_q[k]   <= (budget_q[k] <= PW'(1));
               end
            end else begin
               tick_q[k] <= 1'b0;
            end

            if (to_shadow[k]) begin
               sh_max_q[k]    <= cfg.cfg_max;
               sh_inc_q[k]    <= cfg.cfg_inc;
               sh_phase_q[k]  <= cfg.cfg_phase;
               sh_npulse_q[k] <= cfg_np;
               sh_mode_q[k]   <= cfg.cfg_mode;
               sh_down_q[k]   <= cfg.cfg_down;
               pend_q[k]      <= 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_cnt
      assign cnt_o[k*N +: N] = cnt_q[k];
   end

   assign tick_o = tick_q;
   assign done_o = done_q;
   assign pend_o = pend_q;

endmodule

// File: tb/tb_gnrc_fractional_counter_mc.sv
// Directed bench for gnrc_fractional_counter_mc with hand-computed expectations.
module tb_gnrc_fractional_counter_mc;
   localparam int N  = 8;
   localparam int CH = 4;
   localparam int PW = 8;
   localparam int CW = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [CH-1:0] en_i, clr_i;
   logic [CH*N-1:0] cnt_o;
   logic [CH-1:0] tick_o, done_o, pend_o;

   int errors = 0;
   int checks = 0;
   int ticks;
   logic [5:0] exp_tick;

   gnrc_fractional_counter_mc_if #(.N(N), .CH(CH), .PW(PW), .CW(CW)) cfg_if ();

   gnrc_fractional_counter_mc #(.N(N), .CH(CH), .PW(PW), .CW(CW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cfg    (cfg_if),
      .en_i   (en_i),
      .clr_i  (clr_i),
      .cnt_o  (cnt_o),
      .tick_o (tick_o),
      .done_o (done_o),
      .pend_o (pend_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] cnt_of(input int k);
      return cnt_o[k*N +: N];
   endfunction

   task automatic send_cfg(input int ch, input int mx, input int inc, input int ph,
                           input int np, input logic mode, input logic down, input logic sync);
      cfg_if.cfg_ch     = CW'(ch);
      cfg_if.cfg_max    = N'(mx);
      cfg_if.cfg_inc    = N'(inc);
      cfg_if.cfg_phase  = N'(ph);
      cfg_if.cfg_npulse = PW'(np);
      cfg_if.cfg_mode   = mode;
      cfg_if.cfg_down   = down;
      cfg_if.cfg_sync   = sync;
      cfg_if.cfg_valid  = 1'b1;
      step();
      cfg_if.cfg_valid  = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      en_i   = '0;
      clr_i  = '0;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_ch     = '0;
      cfg_if.cfg_max    = '0;
      cfg_if.cfg_inc    = '0;
      cfg_if.cfg_phase  = '0;
      cfg_if.cfg_npulse = '0;
      cfg_if.cfg_mode   = 1'b0;
      cfg_if.cfg_down   = 1'b0;
      cfg_if.cfg_sync   = 1'b0;
      step();
      step();
      chk("rst_cnt", cnt_o, 0);
      chk("rst_tick", tick_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_pend", pend_o, 0);
      chk("rst_err", cfg_if.cfg_err, 0);
      rst_ni = 1'b1;
      step();
      chk("rdy_after_rst", cfg_if.cfg_ready, 1);

      // ch0 up: max=15 inc=5
      send_cfg(0, 15, 5, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("c0_load", cnt_of(0), 0);
      en_i[0] = 1'b1;
      ticks = 0;
      step(); chk("c0_e1", cnt_of(0), 5);
      step(); chk("c0_e2", cnt_of(0), 10);
      step(); chk("c0_e3", cnt_of(0), 15); chk("c0_e3_tick", tick_o[0], 0);
      step(); chk("c0_e4", cnt_of(0), 4);  chk("c0_e4_tick", tick_o[0], 1);
      ticks = 1;
      for (int i = 0; i < 28; i++) begin
         step();
         if (tick_o[0]) ticks++;
      end
      chk("c0_ticks32", ticks, 10);
      chk("c0_cnt32", cnt_of(0), 0);
      en_i[0] = 1'b0;
      step();
      chk("c0_hold_tick", tick_o[0], 0);

      // ch1 down: max=9 inc=3 phase=9
      send_cfg(1, 9, 3, 9, 0, 1'b1, 1'b1, 1'b0);
      chk("c1_load", cnt_of(1), 9);
      en_i[1] = 1'b1;
      step(); chk("c1_e1", cnt_of(1), 6);
      step(); chk("c1_e2", cnt_of(1), 3);
      step(); chk("c1_e3", cnt_of(1), 0);
      step(); chk("c1_e4", cnt_of(1), 7); chk("c1_e4_tick", tick_o[1], 1);
      ticks = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (tick_o[1]) ticks++;
      end
      chk("c1_ticks10", ticks, 3);
      chk("c1_cnt10", cnt_of(1), 9);
      en_i[1] = 1'b0;
      chk("c0_undisturbed", cnt_of(0), 0);

      // ch2 one-shot: npulse=3 max=3 inc=2
      send_cfg(2, 3, 2, 0, 3, 1'b0, 1'b0, 1'b0);
      en_i[2] = 1'b1;
      exp_tick = 6'b101010;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("c2_tick", tick_o[2], exp_tick[i]);
         chk("c2_cnt", cnt_of(2), (i % 2 == 0) ? 2 : 0);
      end
      chk("c2_done", done_o[2], 1);
      for (int i = 0; i < 4; i++) begin
         en_i[2] = ~en_i[2];
         step();
         chk("c2_frozen_tick", tick_o[2], 0);
         chk("c2_frozen_cnt", cnt_of(2), 0);
      end
      chk("c2_done_held", done_o[2], 1);
      en_i[2]  = 1'b0;
      clr_i[2] = 1'b1;
      step();
      clr_i[2] = 1'b0;
      chk("c2_clr_done", done_o[2], 0);
      en_i[2] = 1'b1;
      step(); chk("c2_restart_cnt", cnt_of(2), 2);
      step(); chk("c2_restart_tick", tick_o[2], 1);
      en_i[2] = 1'b0;

      // ch3 sync reconfiguration
      send_cfg(3, 7, 1, 0, 0, 1'b1, 1'b0, 1'b0);
      en_i[3] = 1'b1;
      step(); step(); step();
      chk("c3_run", cnt_of(3), 3);
      send_cfg(3, 7, 4, 2, 0, 1'b1, 1'b0, 1'b1);
      chk("c3_pend", pend_o[3], 1);
      chk("c3_cnt_acc", cnt_of(3), 4);
      cfg_if.cfg_ch = 2'd3;
      #1 chk("c3_rdy_low", cfg_if.cfg_ready, 0);
      cfg_if.cfg_ch = 2'd0;
      #1 chk("c0_rdy_high", cfg_if.cfg_ready, 1);
      step(); chk("c3_s1", cnt_of(3), 5);
      step(); chk("c3_s2", cnt_of(3), 6);
      step(); chk("c3_s3", cnt_of(3), 7); chk("c3_s3_pend", pend_o[3], 1);
      step(); chk("c3_wrap_cnt", cnt_of(3), 2);
      chk("c3_wrap_tick", tick_o[3], 1);
      chk("c3_wrap_pend", pend_o[3], 0);
      step(); chk("c3_n1", cnt_of(3), 6); chk("c3_n1_tick", tick_o[3], 0);
      step(); chk("c3_n2", cnt_of(3), 2); chk("c3_n2_tick", tick_o[3], 1);

      // config errors leave ch0 untouched
      send_cfg(0, 7, 8, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("err_inc", cfg_if.cfg_err, 1);
      chk("err_cnt_kept", cnt_of(0), 0);
      step();
      chk("err_one_cycle", cfg_if.cfg_err, 0);
      send_cfg(0, 7, 1, 9, 0, 1'b1, 1'b0, 1'b0);
      chk("err_phase", cfg_if.cfg_err, 1);
      en_i[0] = 1'b1;
      step(); step();
      chk("err_cfg_kept", cnt_of(0), 10);
      en_i[0] = 1'b0;

      // config and clear on the same edge: config wins
      clr_i[0] = 1'b1;
      send_cfg(0, 15, 3, 7, 0, 1'b1, 1'b0, 1'b0);
      clr_i[0] = 1'b0;
      chk("cfgclr_cnt", cnt_of(0), 7);
      chk("cfgclr_noerr", cfg_if.cfg_err, 0);
      en_i[0] = 1'b1;
      step();
      chk("cfgclr_inc", cnt_of(0), 10);
      en_i[0] = 1'b0;

      // reset while a sync config is pending
      send_cfg(3, 7, 1, 5, 0, 1'b1, 1'b0, 1'b1);
      chk("mid_pend", pend_o[3], 1);
      rst_ni = 1'b0;
      step();
      chk("mid_rst_cnt", cnt_o, 0);
      chk("mid_rst_tick", tick_o, 0);
      chk("mid_rst_done", done_o, 0);
      chk("mid_rst_pend", pend_o, 0);
      rst_ni = 1'b1;
      en_i   = '1;
      ticks  = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (tick_o != '0) ticks++;
      end
      chk("post_rst_cnt", cnt_o, 0);
      chk("post_rst_ticks", ticks, 0);
      cfg_if.cfg_ch = 2'd3;
      #1 chk("post_rst_rdy", cfg_if.cfg_ready, 1);
      send_cfg(0, 15, 5, 0, 0, 1'b1, 1'b0, 1'b0);
      step();
      chk("post_rst_resume", cnt_of(0), 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
